// File: rtl/toggle_checker_pkg.sv
// toggle_checker_pkg: state encoding and default parameters shared by the toggle checker.
package toggle_checker_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2,
        STUCK = 2'd3
    } state_t;

    localparam int CNT_W_DEF     = 8;
    localparam int STUCK_LIM_DEF = 4;
endpackage

// File: rtl/toggle_checker_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/toggle_checker.sv
// toggle_checker: counts toggles of a monitored bit and raises a handshaked error when it sticks.
module toggle_checker
    import toggle_checker_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int STUCK_LIM = STUCK_LIM_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic             BIT_IN,
    input  logic             ERR_READY,
    output logic [CNT_W-1:0] TOGGLE_CNT,
    output logic             ERR_VALID,
    output logic [1:0]       STATE
);
    state_t     state_q, state_d;
    logic       prev_q, prev_d;
    logic [3:0] stuck_q, stuck_d;
    logic       err_q, err_d;
    logic       inc;

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            stuck_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            stuck_q <= stuck_d;
            err_q   <= err_d;
        end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        stuck_d = stuck_q;
        err_d   = err_q;
        inc     = 1'b0;
        if (CLR) begin
            state_d = IDLE;
            stuck_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (EN) begin
                    prev_d  = BIT_IN;
                    state_d = ARMED;
                end
                ARMED, TRACK: if (EN) begin
                    prev_d = BIT_IN;
                    if (BIT_IN != prev_q) begin
                        inc     = 1'b1;
                        stuck_d = '0;
                        state_d = TRACK;
                    end else begin
                        stuck_d = stuck_q + 4'd1;
                        if (stuck_d == 4'(STUCK_LIM)) begin
                            state_d = STUCK;
                            err_d   = 1'b1;
                        end
                    end
                end
                // the handshake ignores EN so a stuck report can always drain
                STUCK: if (err_q && ERR_READY) begin
                    err_d   = 1'b0;
                    stuck_d = '0;
                    prev_d  = BIT_IN;
                    state_d = ARMED;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk_i (CLK),
        .rst_ni(RST),
        .inc_i (inc),
        .clr_i (CLR),
        .cnt_o (TOGGLE_CNT)
    );

    assign ERR_VALID = err_q;
    assign STATE     = state_q;
endmodule

// File: tb/tb_toggle_checker.sv
// tb_toggle_checker: directed and randomized checks of toggle_checker against a behavioural model.
module tb_toggle_checker;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0, CLR = 1'b0, BIT_IN = 1'b0, ERR_READY = 1'b0;
    logic [7:0] cnt8;
    logic [2:0] cnt3;
    logic       err8, err3;
    logic [1:0] st8, st3;

    int checks = 0;
    int errors = 0;

    int m_state, m_cnt, m_cnt3, m_run;
    bit m_prev, m_err;

    always #5 CLK = ~CLK;

    toggle_checker u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .BIT_IN(BIT_IN), .ERR_READY(ERR_READY),
        .TOGGLE_CNT(cnt8), .ERR_VALID(err8), .STATE(st8)
    );

    toggle_checker #(.CNT_W(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .BIT_IN(BIT_IN), .ERR_READY(ERR_READY),
        .TOGGLE_CNT(cnt3), .ERR_VALID(err3), .STATE(st3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_cnt3 = 0; m_run = 0; m_prev = 0; m_err = 0;
    endtask

    // 0=idle 1=armed 2=tracking 3=stuck, as observable on STATE
    task automatic model_edge();
        if (CLR) begin
            m_state = 0; m_cnt = 0; m_cnt3 = 0; m_run = 0; m_err = 0;
        end else if (m_state == 3) begin
            if (ERR_READY) begin
                m_err = 0; m_run = 0; m_prev = BIT_IN; m_state = 1;
            end
        end else if (EN) begin
            if (m_state == 0) m_state = 1;
            else if (BIT_IN != m_prev) begin
                m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
                m_cnt3 = (m_cnt3 < 7)   ? m_cnt3 + 1 : 7;
                m_run = 0;
                m_state = 2;
            end else begin
                m_run++;
                if (m_run == 4) begin
                    m_state = 3; m_err = 1;
                end
            end
            m_prev = BIT_IN;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"}, int'(st8), m_state);
        chk({tag, "_cnt"}, int'(cnt8), m_cnt);
        chk({tag, "_err"}, int'(err8), int'(m_err));
        chk({tag, "_cnt3"}, int'(cnt3), m_cnt3);
        chk({tag, "_state3"}, int'(st3), m_state);
    endtask

    task automatic step(input bit en, input bit clr, input bit b, input bit rdy, input string tag);
        EN = en; CLR = clr; BIT_IN = b; ERR_READY = rdy;
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 RST = 1'b0;
        model_reset();
        #1 check_all(tag);
        #1 RST = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 check_all("rst");
        #7 RST = 1'b1;

        for (int i = 0; i < 5; i++) step(1, 0, 1'(i % 2), 0, "alt");
        chk("alt_cnt_abs", int'(cnt8), 4);
        chk("alt_state_abs", int'(st8), 2);

        pulse_reset("rst2");
        step(1, 0, 1, 0, "arm");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, "hold");
        chk("stuck_err_abs", int'(err8), 1);
        chk("stuck_state_abs", int'(st8), 3);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "wait");
        step(0, 0, 0, 1, "hs");
        chk("hs_state_abs", int'(st8), 1);
        chk("hs_err_abs", int'(err8), 0);
        step(1, 0, 1, 1, "rdy_idle");

        pulse_reset("rst3");
        for (int i = 0; i < 10; i++) step(1, 0, 1'(i % 2), 0, "sat");
        chk("sat3_abs", int'(cnt3), 7);
        step(1, 0, 0, 0, "sat_hold");

        for (int i = 0; i < 8; i++) step(1'(i % 2 == 0), 0, 1'(i % 2 == 0 ? i / 2 % 2 : 1), 0, "en_mix");
        for (int i = 0; i < 10; i++) step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "en_off");

        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, "to_stuck");
        step(1, 1, 0, 1, "clr_stuck");
        chk("clr_state_abs", int'(st8), 0);
        chk("clr_cnt_abs", int'(cnt8), 0);

        pulse_reset("rst4");
        for (int i = 0; i < 4; i++) step(1, 0, 1'(i % 2), 0, "pre_rst");
        chk("pre_rst_cnt_abs", int'(cnt8), 3);
        pulse_reset("mid_rst");
        step(1, 0, 1, 0, "post_rst");
        chk("post_rst_state_abs", int'(st8), 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/toggle_checker.md
TOGGLE_CHECKER -- requirements
Module: toggle_checker

Interface
REQ-001 Parameter CNT_W, default 8, width of the toggle counter.
REQ-002 Parameter STUCK_LIM, default 4, consecutive enabled non-toggle samples that declare a stuck bit; legal range 1..15.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 EN  input  1  sample enable; when 0, all state holds.
REQ-006 CLR  input  1  synchronous clear of counter, FSM and error; priority over EN.
REQ-007 BIT_IN  input  1  monitored bit from the upstream toggle register, sampled when EN=1.
REQ-008 ERR_READY  input  1  consumer accepts the stuck error.
REQ-009 TOGGLE_CNT  output  CNT_W  registered count of observed toggles.
REQ-010 ERR_VALID  output  1  registered stuck-error request.
REQ-011 STATE  output  2  registered FSM state: IDLE=0, ARMED=1, TRACK=2, STUCK=3.

Function
REQ-012 An enabled sample is a rising CLK edge with EN=1 and CLR=0; only enabled samples change state, prev_bit, stuck_cnt or TOGGLE_CNT.
REQ-013 IDLE: an enabled sample loads prev_bit<=BIT_IN and moves to ARMED; no counting occurs.
REQ-014 ARMED and TRACK: a toggle is an enabled sample with BIT_IN!=prev_bit; each enabled sample loads prev_bit<=BIT_IN.
REQ-015 On a toggle: TOGGLE_CNT increments, stuck_cnt<=0, state<=TRACK.
REQ-016 On a non-toggle: stuck_cnt increments; when the incremented value equals STUCK_LIM, state<=STUCK and ERR_VALID<=1 on the same edge.
REQ-017 TOGGLE_CNT saturates at 2^CNT_W-1 and does not wrap.
REQ-018 STUCK: ERR_VALID stays 1 until the edge where ERR_VALID=1 and ERR_READY=1 (handshake); that edge drives ERR_VALID<=0, stuck_cnt<=0, prev_bit<=BIT_IN, state<=ARMED.
REQ-019 STUCK: the handshake completes regardless of EN; toggles seen in STUCK are not counted.
REQ-020 ERR_READY has no effect while ERR_VALID=0.
REQ-021 CLR=1: TOGGLE_CNT<=0, stuck_cnt<=0, ERR_VALID<=0, state<=IDLE next edge, irrespective of EN, ERR_READY or state; a pending error is dropped without handshake.
REQ-022 Latency: a toggle sampled on edge N is visible on TOGGLE_CNT after edge N; stuck detection is asserted after the STUCK_LIM-th consecutive non-toggle edge.
REQ-023 All outputs are driven directly from flops; no combinational input-to-output path.

Reset
REQ-024 RST=0 asynchronously forces state=IDLE, TOGGLE_CNT=0, ERR_VALID=0, stuck_cnt=0, prev_bit=0.
REQ-025 Reset asserted mid-operation, including STUCK with ERR_VALID=1, aborts immediately; no handshake is owed.
REQ-026 Release of RST is synchronous to CLK; the first enabled sample after release follows IDLE rules.

Structure
REQ-027 Shared package holds the state encoding constants (IDLE, ARMED, TRACK, STUCK), the 2-bit state type, and the CNT_W and STUCK_LIM defaults.
REQ-028 One sub-module, sat_counter (parameterised width, inc and clr inputs, saturating output), implements TOGGLE_CNT; stuck_cnt is a 4-bit register internal to the top.

Verification
REQ-029 Reset, EN=1, BIT_IN alternating 0,1,0,1,0 over 5 edges -> STATE IDLE,ARMED,TRACK,TRACK,TRACK; TOGGLE_CNT=4; ERR_VALID=0.
REQ-030 After ARMED, BIT_IN held 1 for 4 edges with STUCK_LIM=4 -> ERR_VALID=1 and STATE=3 after the 4th edge; ERR_READY held 0 for 3 edges -> ERR_VALID stays 1; ERR_READY=1 -> next edge ERR_VALID=0, STATE=1.
REQ-031 CNT_W=3, 10 alternating samples -> TOGGLE_CNT reaches 7 and holds 7.
REQ-032 EN toggled 1,0,1,0 with BIT_IN alternating every cycle -> only EN=1 edges count; with EN=0 for 10 edges, no state or count change.
REQ-033 In STUCK with ERR_VALID=1, assert CLR and ERR_READY on the same edge -> STATE=0, ERR_VALID=0, TOGGLE_CNT=0.
REQ-034 In TRACK with TOGGLE_CNT=3, pulse RST low between clock edges -> all outputs 0 immediately; after release, counting restarts from IDLE.
